// File: rtl/core_bus_pkg.sv
// Shared types for the core bus arbiter: requester index,
// selection FSM states and the requester-count ceiling.
package core_bus_pkg;

   localparam int MAX_REQ = 8;

   // Wide enough for the largest legal requester count, so a single
   // type serves every arbiter configuration and its ID FIFO.
   typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_e;

endpackage

// File: rtl/core_bus_if.sv
// Core-side data port bundle (req/gnt/rvalid protocol).
// master: drives req + payload; slave: returns gnt, rvalid, rdata.
interface core_bus_if #(
   parameter int ADDR_WIDTH = 32
) ();

   logic                  req;
   logic                  gnt;
   logic                  rvalid;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  we;
   logic [3:0]            be;
   logic [31:0]           wdata;
   logic [31:0]           rdata;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/core_bus_id_fifo.sv
// In-order FIFO of requester IDs for granted transactions.
// Ports: push/data_in write, pop retires head, full/empty status.
module core_bus_id_fifo
   import core_bus_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     push,
   input  logic     pop,
   input  req_idx_t data_in,
   output req_idx_t head,
   output logic     full,
   output logic     empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   req_idx_t      r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full   = (r_cnt == CW'(DEPTH));
   assign empty  = (r_cnt == '0);
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign head   = r_mem[r_rd];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= f_inc(r_wr);
         if (w_pop)  r_rd <= f_inc(r_rd);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr] <= data_in;
   end

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one core data port among NUM_REQ requesters.
// Ports: req/addr/we/be/wdata_i in, gnt/rvalid/rdata_o out, m_bus downstream, err_o sticky.
module core_bus_arbiter
   import core_bus_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NUM_REQ-1:0]                  req_i,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_i,
   input  logic [NUM_REQ-1:0]                  we_i,
   input  logic [NUM_REQ-1:0][3:0]             be_i,
   input  logic [NUM_REQ-1:0][31:0]            wdata_i,
   output logic [NUM_REQ-1:0]                  gnt_o,
   output logic [NUM_REQ-1:0]                  rvalid_o,
   output logic [31:0]                         rdata_o,
   output logic                                err_o,
   core_bus_if.master                          m_bus
);

   localparam int IW = $bits(req_idx_t);
   localparam int SW = IW + 1;

   arb_state_e           r_state;
   req_idx_t             r_prio;
   req_idx_t             r_lock;
   logic                 r_err;

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   req_idx_t             w_ofs;
   logic [SW-1:0]        w_sum;
   req_idx_t             w_srch;
   req_idx_t             w_sel;
   req_idx_t             w_next;
   req_idx_t             w_head;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_mreq;
   logic                 w_push;
   logic                 w_pop;

   // Rotate so prio_q sits at bit 0, find the first set bit,
   // then rotate the offset back into requester numbering.
   always_comb begin
      w_dbl = {req_i, req_i} >> r_prio;
      w_rot = w_dbl[NUM_REQ-1:0];
      w_ofs = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) w_ofs = req_idx_t'(i);
      end
      w_sum = {1'b0, r_prio} + {1'b0, w_ofs};
      if (w_sum >= SW'(NUM_REQ)) w_sum = w_sum - SW'(NUM_REQ);
      w_srch = w_sum[IW-1:0];
   end

   // A locked selection is never re-arbitrated: the bridge may
   // already hold part of this payload.
   assign w_sel   = (r_state == LOCKED) ? r_lock : w_srch;
   assign w_next  = (w_sel == req_idx_t'(NUM_REQ - 1)) ? '0 : w_sel + req_idx_t'(1);
   assign w_mreq  = (r_state == LOCKED) || ((|req_i) && !w_full);
   assign w_push  = w_mreq && m_bus.gnt;
   assign w_pop   = m_bus.rvalid && !w_empty;
   assign m_bus.req = w_mreq;
   assign rdata_o = m_bus.rdata;
   assign err_o   = r_err;

   always_comb begin
      m_bus.addr  = addr_i[0];
      m_bus.we    = we_i[0];
      m_bus.be    = be_i[0];
      m_bus.wdata = wdata_i[0];
      gnt_o       = '0;
      rvalid_o    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sel == req_idx_t'(i)) begin
            m_bus.addr  = addr_i[i];
            m_bus.we    = we_i[i];
            m_bus.be    = be_i[i];
            m_bus.wdata = wdata_i[i];
            gnt_o[i]    = w_push;
         end
         if (w_head == req_idx_t'(i)) rvalid_o[i] = w_pop;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_prio  <= '0;
         r_lock  <= '0;
         r_err   <= 1'b0;
      end else begin
         if (m_bus.rvalid && w_empty) r_err <= 1'b1;
         if (w_push) r_prio <= w_next;
         unique case (r_state)
            IDLE: begin
               if (w_mreq && !m_bus.gnt) begin
                  r_lock  <= w_sel;
                  r_state <= LOCKED;
               end
            end
            LOCKED: begin
               if (m_bus.gnt) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   core_bus_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push    (w_push),
      .pop     (w_pop),
      .data_in (w_sel),
      .head    (w_head),
      .full    (w_full),
      .empty   (w_empty)
   );

endmodule
